uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial-to-parallel receiver of the UART.
- Oversamples the rx line using the baud generator's s_tick and deserialises one frame: start, DBIT data bits LSB first, optional parity, stop.
- Sits between the baud generator and the RX FIFO. Each received byte is presented with a one-cycle rx_done_tick, which drives the FIFO write strobe.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, s_ticks spent in the stop phase (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OVERSAMPLE, 16, s_ticks per bit period; must be an even power of two.
- PARITY_ODD, 0, used only under UART_RX_PARITY_EN. 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- s_tick  input  1  oversample strobe from baud generator, one clk wide, OVERSAMPLE per bit
- rx  input  1  asynchronous serial line, idle high
- rx_done_tick  output  1  one-clk pulse: frame complete, dout/frame_err/parity_err valid
- dout  output  DBIT  received data word
- frame_err  output  1  stop bit sampled low on the last frame
- parity_err  output  1  parity mismatch on the last frame

Behaviour:
- One clock, clk. reset_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; s_cnt = 0; n_cnt = 0; shift register = 0.
  - rx synchroniser flops = 1.
  - rx_done_tick = 0; dout = 0; frame_err = 0; parity_err = 0; brk_wait = 0.
- Reset mid-frame aborts the frame silently; no rx_done_tick is produced.
- rx passes through a 2-flop synchroniser (rx_s). This adds 2 clk latency to all line observations.
- s_cnt is log2(max(OVERSAMPLE,SB_TICK)) bits wide. n_cnt is 3 bits.
- All transitions other than leaving IDLE happen only on clocks where s_tick = 1.
- IDLE:
  - If brk_wait = 1, wait for rx_s = 1, then clear brk_wait.
  - Otherwise, rx_s = 0 → START with s_cnt = 0. This transition does not need s_tick.
- START:
  - At s_cnt = OVERSAMPLE/2-1 (mid start bit):
    - rx_s = 0 → DATA, s_cnt = 0, n_cnt = 0.
    - rx_s = 1 → IDLE (glitch rejected, no output).
  - Otherwise s_cnt++.
- DATA:
  - At s_cnt = OVERSAMPLE-1: shift rx_s into the MSB of the DBIT shift register (LSB first on the line) and set s_cnt = 0.
  - If n_cnt = DBIT-1 → PARITY (macro on) or STOP; otherwise n_cnt++.
- STOP:
  - At s_cnt = OVERSAMPLE-1: latch stop_ok = rx_s.
  - At s_cnt = SB_TICK-1:
    - Pulse rx_done_tick for exactly one clk.
    - Load dout from the shift register.
    - Set frame_err = ~stop_ok. When SB_TICK = OVERSAMPLE, use the rx_s of this same tick instead of stop_ok.
    - Return to IDLE.
- A frame error also sets brk_wait = 1. This means a held-low line (break) produces exactly one frame_err frame, not a stream of 0x00 frames.
- dout, frame_err and parity_err hold their values until the next rx_done_tick.
- Back-to-back frames are accepted: IDLE can detect the next start bit on the clock after rx_done_tick.
- s_tick held low freezes the state machine; no timeout.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - State PARITY is inserted between DATA and STOP.
  - At s_cnt = OVERSAMPLE-1, sample rx_s as the parity bit p and go to STOP with s_cnt = 0.
  - At the rx_done_tick, parity_err = (^data ^ p ^ PARITY_ODD).
- Undefined:
  - No PARITY state exists.
  - parity_err is tied to 0.
  - PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam OVERSAMPLE_DEF = 16;
  - localparam DBIT_DEF = 8.
- Sub-module uart_sync2: a generic 2-flop synchroniser with parameterised reset value (here 1). It is reused for any asynchronous UART input.

Test Plan:
- Common setup: s_tick every 4 clk (OVERSAMPLE = 16, so 64 clk per bit).
- Clean frame: send 0xA5 with stop = 1 → one rx_done_tick, dout = 0xA5, frame_err = 0, pulse ≤ 1 bit-time after the stop-bit midpoint.
- Glitch: rx low for 3 s_ticks, then high → no rx_done_tick, state back in IDLE, dout unchanged.
- Framing/break: send 0x3C with stop = 0, then hold rx low for 3 frames → exactly one rx_done_tick with dout = 0x3C, frame_err = 1. No further ticks until rx returns high.
- Next frame after break: release rx high, then send 0x81 → dout = 0x81, frame_err = 0.
- Reset mid-frame: assert reset_n low after 4 data bits of 0xFF → all outputs 0 immediately. After reset is released, frame 0x5A is received correctly.
- Back-to-back and parity: send 0x00 then 0xFF with no idle gap → two rx_done_ticks, in order. Under UART_RX_PARITY_EN with even parity, send 0x07 with parity bit 0 → parity_err = 1; send 0x07 with parity bit 1 → parity_err = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART receive path.
//   uart_rx_state_t : receiver FSM states (PARITY is only entered when the
//                     receiver is built with UART_RX_PARITY_EN defined)
//   OVERSAMPLE_DEF  : default s_ticks per bit period
//   DBIT_DEF        : default data bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DBIT_DEF       = 8;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Generic two-flop synchroniser for asynchronous UART inputs.
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset; both flops load RST_VAL
//   d       : asynchronous input
//   q       : synchronised output (2 clk latency)
// Parameters:
//   RST_VAL : reset value of both flops (1 for an idle-high serial line)
// -----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start bit, DBIT data bits LSB first, optional
// parity bit, stop phase of SB_TICK s_ticks. Each frame ends with a one-clk
// rx_done_tick that writes the RX FIFO.
//
// Build option:
//   UART_RX_PARITY_EN : when defined, a parity bit follows the data bits and
//                       is checked against PARITY_ODD (0 = even, 1 = odd).
//                       When undefined, there is no parity phase, the
//                       PARITY_ODD parameter does not exist and parity_err
//                       is constant 0.
//
// Ports:
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   s_tick       : oversample strobe, OVERSAMPLE per bit period, one clk wide
//   rx           : asynchronous serial line, idle high
//   rx_done_tick : one-clk pulse, frame complete; dout/errors valid
//   dout         : received data word (held until next rx_done_tick)
//   frame_err    : stop bit sampled low on the last frame
//   parity_err   : parity mismatch on the last frame
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int SB_TICK    = 16,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int CNT_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_OS   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] LAST_SB   = CNT_W'(SB_TICK - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DBIT - 1);

  // With a single stop bit the mid-stop sample and the end of the stop
  // phase fall on the same tick, so the live sample is used directly.
  localparam bit STOP_SAME_TICK = (SB_TICK == OVERSAMPLE);

  // ---------------------------------------------------------------------------
  // Line synchroniser (idle-high reset so no false start after reset)
  // ---------------------------------------------------------------------------
  logic rx_s;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] s_cnt_q, s_cnt_d;
  logic [2:0]       n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]  sh_q, sh_d;
  logic             stop_ok_q, stop_ok_d;
  logic             brk_wait_q, brk_wait_d;
  logic             rx_done_q, rx_done_d;
  logic [DBIT-1:0]  dout_q, dout_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
`endif

  logic             stop_bit;

  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    n_cnt_d      = n_cnt_q;
    sh_d         = sh_q;
    stop_ok_d    = stop_ok_q;
    brk_wait_d   = brk_wait_q;
    rx_done_d    = 1'b0;
    dout_d       = dout_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
`endif
    stop_bit     = STOP_SAME_TICK ? rx_s : stop_ok_q;

    case (state_q)
      IDLE: begin
        // After a framing error, the line must return high before a new
        // start bit is accepted; a held break yields only one frame.
        if (brk_wait_q) begin
          if (rx_s) begin
            brk_wait_d = 1'b0;
          end
        end else if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == MID_START) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              // Line went back high before mid start bit: glitch.
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_OS) begin
            // LSB arrives first, so shifting in at the MSB leaves the
            // word correctly aligned after DBIT bits.
            sh_d    = {rx_s, sh_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + CNT_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_OS) begin
            par_bit_d = rx_s;
            state_d   = STOP;
            s_cnt_d   = '0;
          end else begin
            s_cnt_d = s_cnt_q + CNT_W'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_OS) begin
            stop_ok_d = rx_s;
          end
          if (s_cnt_q == LAST_SB) begin
            rx_done_d   = 1'b1;
            dout_d      = sh_q;
            frame_err_d = ~stop_bit;
            if (!stop_bit) begin
              brk_wait_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_d = (^sh_q) ^ par_bit_q ^ 1'(PARITY_ODD);
`else
            parity_err_d = 1'b0;
`endif
            state_d = IDLE;
            s_cnt_d = '0;
          end else begin
            s_cnt_d = s_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      s_cnt_q      <= '0;
      n_cnt_q      <= '0;
      sh_q         <= '0;
      stop_ok_q    <= 1'b0;
      brk_wait_q   <= 1'b0;
      rx_done_q    <= 1'b0;
      dout_q       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      n_cnt_q      <= n_cnt_d;
      sh_q         <= sh_d;
      stop_ok_q    <= stop_ok_d;
      brk_wait_q   <= brk_wait_d;
      rx_done_q    <= rx_done_d;
      dout_q       <= dout_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
`endif
    end
  end

  assign rx_done_tick = rx_done_q;
  assign dout         = dout_q;
  assign frame_err    = frame_err_q;
  assign parity_err   = parity_err_q;

endmodule : uart_rx
